// File: rtl/fc_classify.sv
// fc_classify: fully-connected output layer + argmax.
// Streams IN_LEN flattened elements, runs NUM_CLASS signed MACs in parallel
// against a synchronous weight ROM, then scans the accumulators for the
// winning class and pulses predict_end to recycle the flattener.
// Optional macro FC_BIAS_EN adds a per-class bias before the argmax scan.
module fc_classify #(
    parameter int DATA_WIDTH = 32,
    parameter int WT_WIDTH   = 16,
    parameter int IN_LEN     = 75,
    parameter int NUM_CLASS  = 10,
    parameter int ADDR_WIDTH = 7,
    parameter int ACC_WIDTH  = 55
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic signed [DATA_WIDTH-1:0]      data_in,
    input  logic                              data_in_valid,
    output logic [ADDR_WIDTH-1:0]             wt_addr,
    output logic                              wt_rd_en,
    input  logic [NUM_CLASS*WT_WIDTH-1:0]     wt_data,
`ifdef FC_BIAS_EN
    input  logic [NUM_CLASS*WT_WIDTH-1:0]     bias_data,
`endif
    output logic [$clog2(NUM_CLASS)-1:0]      class_id,
    output logic [ACC_WIDTH-1:0]              class_score,
    output logic                              class_valid,
    output logic                              predict_end,
    output logic                              busy,
    output logic                              err_overrun
);
    localparam int CID_W  = $clog2(NUM_CLASS);
    localparam int ARG_W  = $clog2(NUM_CLASS + 1);
    localparam int PROD_W = DATA_WIDTH + WT_WIDTH;
`ifdef FC_BIAS_EN
    localparam int ARG_OFF = 1;   // ARGMAX cycle 0 folds the bias in
`else
    localparam int ARG_OFF = 0;
`endif
    localparam int ARG_LAST = NUM_CLASS - 1 + ARG_OFF;

    typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_ARGMAX, S_DONE} state_t;

    state_t                         state_q;
    logic [ADDR_WIDTH-1:0]          elem_cnt_q;
    logic signed [DATA_WIDTH-1:0]   data_q;
    logic                           mac_q;      // an add is due this cycle
    logic                           last_q;     // final element's add is due
    logic [ARG_W-1:0]               arg_cnt_q;
    logic signed [ACC_WIDTH-1:0]    best_q;
    logic [CID_W-1:0]               best_idx_q;
    logic [CID_W-1:0]               class_id_q;
    logic signed [ACC_WIDTH-1:0]    class_score_q;
    logic                           class_valid_q;
    logic                           predict_end_q;
    logic                           err_q;
    logic signed [ACC_WIDTH-1:0]    acc_q [NUM_CLASS];

    logic                           accept;
    logic                           cmp_en;
    logic [ARG_W-1:0]               cmp_idx;
    logic signed [ACC_WIDTH-1:0]    cand;
    logic                           take;
    logic signed [ACC_WIDTH-1:0]    nxt_best;
    logic [CID_W-1:0]               nxt_idx;

    // The cycle carrying the last element's add is still ACCUM, but a new
    // element there would alias element 0 of the next frame, so it is refused.
    assign accept   = data_in_valid &&
                      (state_q == S_IDLE || (state_q == S_ACCUM && !last_q));
    assign wt_rd_en = accept;
    assign wt_addr  = elem_cnt_q;
    assign cmp_idx  = arg_cnt_q - ARG_W'(ARG_OFF);
`ifdef FC_BIAS_EN
    assign cmp_en   = (arg_cnt_q != '0);
`else
    assign cmp_en   = 1'b1;
`endif

    // Candidate select and strict signed compare; ties keep the lower index.
    always_comb begin
        cand = acc_q[0];
        for (int k = 0; k < NUM_CLASS; k++)
            if (cmp_idx == ARG_W'(k)) cand = acc_q[k];
        take     = (cmp_idx == '0) || (cand > best_q);
        nxt_best = take ? cand : best_q;
        nxt_idx  = take ? cmp_idx[CID_W-1:0] : best_idx_q;
    end

    // Per-class accumulator: MAC one cycle after the ROM read, cleared in DONE.
    for (genvar k = 0; k < NUM_CLASS; k++) begin : g_lane
        logic signed [PROD_W-1:0] prod;
        assign prod = PROD_W'(data_q) *
                      PROD_W'($signed(wt_data[k*WT_WIDTH +: WT_WIDTH]));
        always_ff @(posedge clk) begin
            if (rst || state_q == S_DONE)
                acc_q[k] <= '0;
            else if (mac_q)
                acc_q[k] <= acc_q[k] + {{(ACC_WIDTH-PROD_W){prod[PROD_W-1]}}, prod};
`ifdef FC_BIAS_EN
            else if (state_q == S_ARGMAX && arg_cnt_q == '0)
                acc_q[k] <= acc_q[k] + {{(ACC_WIDTH-WT_WIDTH){bias_data[k*WT_WIDTH+WT_WIDTH-1]}},
                                        bias_data[k*WT_WIDTH +: WT_WIDTH]};
`endif
        end
    end

    // Control FSM: element intake, argmax scan and registered result strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            elem_cnt_q    <= '0;
            data_q        <= '0;
            mac_q         <= 1'b0;
            last_q        <= 1'b0;
            arg_cnt_q     <= '0;
            best_q        <= '0;
            best_idx_q    <= '0;
            class_id_q    <= '0;
            class_score_q <= '0;
            class_valid_q <= 1'b0;
            predict_end_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            class_valid_q <= 1'b0;
            predict_end_q <= 1'b0;
            mac_q         <= accept;
            if (data_in_valid && !accept) err_q <= 1'b1;
            if (accept) begin
                data_q <= data_in;
                if (elem_cnt_q == ADDR_WIDTH'(IN_LEN - 1)) begin
                    elem_cnt_q <= '0;
                    last_q     <= 1'b1;
                end else begin
                    elem_cnt_q <= elem_cnt_q + 1'b1;
                end
            end
            case (state_q)
                S_IDLE:   if (accept) state_q <= S_ACCUM;
                S_ACCUM:  if (last_q) begin
                              last_q    <= 1'b0;
                              arg_cnt_q <= '0;
                              state_q   <= S_ARGMAX;
                          end
                S_ARGMAX: begin
                    arg_cnt_q <= arg_cnt_q + 1'b1;
                    if (cmp_en) begin
                        best_q     <= nxt_best;
                        best_idx_q <= nxt_idx;
                    end
                    if (arg_cnt_q == ARG_W'(ARG_LAST)) begin
                        class_id_q    <= nxt_idx;
                        class_score_q <= nxt_best;
                        class_valid_q <= 1'b1;
                        predict_end_q <= 1'b1;
                        state_q       <= S_DONE;
                    end
                end
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign class_id    = class_id_q;
    assign class_score = class_score_q;
    assign class_valid = class_valid_q;
    assign predict_end = predict_end_q;
    assign busy        = (state_q != S_IDLE);
    assign err_overrun = err_q;
endmodule

// File: tb/tb_fc_classify.sv
// Bench for fc_classify: vector table of whole frames, a behavioural weight
// ROM, and a result scoreboard checked when class_valid fires.
module tb_fc_classify;
    localparam int NC = 10, WT = 16, DW = 32, AW = 7, ACCW = 55, CW = 4, LEN = 75;
`ifdef FC_BIAS_EN
    localparam int LAT = NC + 3;
`else
    localparam int LAT = NC + 2;
`endif

    logic                 clk = 1'b0;
    logic                 rst;
    logic signed [DW-1:0] din;
    logic                 dv;
    logic [AW-1:0]        wt_addr;
    logic                 wt_rd_en;
    logic [NC*WT-1:0]     wt_data = '0;
`ifdef FC_BIAS_EN
    logic [NC*WT-1:0]     bias_data = '0;
`endif
    logic [CW-1:0]        class_id;
    logic [ACCW-1:0]      class_score;
    logic                 class_valid, predict_end, busy, err_overrun;

    fc_classify dut (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(dv),
        .wt_addr(wt_addr), .wt_rd_en(wt_rd_en), .wt_data(wt_data),
`ifdef FC_BIAS_EN
        .bias_data(bias_data),
`endif
        .class_id(class_id), .class_score(class_score), .class_valid(class_valid),
        .predict_end(predict_end), .busy(busy), .err_overrun(err_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {int id; longint score; int t_last;} exp_t;
    typedef struct {int wmode; int data; bit gap; bit ovr; int id; longint score;} vec_t;

    exp_t sb[$];
    int   cyc = 0, pass_cnt = 0, total_cnt = 0, n_res = 0, busy_low = 0;
    int   wmode = 0;
    bit   track_busy = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Weight patterns: 0 -> class k weight k, 1 -> all 5, 2 -> -1 except class 3 = 0
    function automatic logic [WT-1:0] wgt(input int mode, input int k);
        case (mode)
            0:       return WT'(k);
            1:       return WT'(5);
            default: return (k == 3) ? '0 : '1;
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous ROM: data one cycle after the read enable.
    always @(posedge clk)
        if (wt_rd_en)
            for (int k = 0; k < NC; k++) wt_data[k*WT +: WT] <= wgt(wmode, k);

    // Result monitor / scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (track_busy && !busy) busy_low++;
        if (class_valid) begin
            n_res++;
            track_busy = 0;
            if (sb.size() == 0) chk("spurious_class_valid", 1, 0);
            else begin
                e = sb.pop_front();
                chk("class_id", longint'(class_id), e.id);
                chk("class_score", longint'($signed(class_score)), e.score);
                chk("latency", cyc - e.t_last, LAT);
                chk("predict_end", predict_end, 1);
            end
        end else if (predict_end) chk("predict_end_alone", 1, 0);
    end

    task automatic drive_elems(input vec_t v, input int n, input bit push);
        wmode = v.wmode;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            din = v.data; dv = 1'b1;
            if (i == 1) track_busy = 1;
            if (i == LEN - 1 && push) begin
                exp_t e;
                e.id = v.id; e.score = v.score; e.t_last = cyc;
                sb.push_back(e);
            end
            if (v.gap) begin @(posedge clk); #1; dv = 1'b0; end
        end
        @(posedge clk); #1; dv = 1'b0;
    endtask

    task automatic wait_result(input int start);
        for (int c = 0; c < 60 && n_res == start; c++) @(posedge clk);
        chk("result_timeout", n_res, start + 1);
    endtask

    vec_t vt[8];
    int   exp_err = 0;

    initial begin
        vt[0] = '{0,  1, 0, 0, 9, 675};
        vt[1] = '{1,  2, 0, 0, 0, 750};
        vt[2] = '{0,  1, 1, 0, 9, 675};
        vt[3] = '{2,  4, 0, 0, 3, 0};
        vt[4] = '{0, -3, 0, 0, 0, 0};
        vt[5] = '{2, -1, 0, 0, 0, 75};
        vt[6] = '{0,  1, 0, 1, 9, 675};
        vt[7] = '{1,  2, 0, 0, 0, 750};

        rst = 1'b1; dv = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_class_valid", class_valid, 0);
        chk("rst_predict_end", predict_end, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_overrun, 0);
        chk("rst_class_id", class_id, 0);
        chk("rst_class_score", longint'(class_score), 0);
        chk("rst_wt_rd_en", wt_rd_en, 0);

        for (int t = 0; t < 8; t++) begin
            int start;
            start = n_res;
            busy_low = 0;
            drive_elems(vt[t], LEN, 1);
            if (vt[t].ovr) begin
                // now in cycle T+1; T+3 and T+5 fall inside ARGMAX
                for (int c = 2; c <= 6; c++) begin
                    @(posedge clk); #1;
                    dv = (c == 3 || c == 5);
                end
                dv = 1'b0;
                exp_err = 1;
            end
            wait_result(start);
            chk("busy_in_frame", busy_low, 0);
            repeat (5) @(posedge clk);
            @(negedge clk);
            chk("class_id_hold", longint'(class_id), vt[t].id);
            chk("err_overrun", err_overrun, exp_err);
        end

        // Reset mid-frame, then a clean frame must score as if fresh.
        drive_elems(vt[0], 40, 0);
        track_busy = 0;
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_err", err_overrun, 0);
        begin
            int start;
            start = n_res;
            busy_low = 0;
            drive_elems(vt[0], LEN, 1);
            wait_result(start);
            chk("busy_after_rst", busy_low, 0);
        end
        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
